// File: rtl/reg_file_pkg.sv
// Shared types and constants for the MIPS general-purpose register file.
package reg_file_pkg;

    localparam int REG_NUM    = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(REG_NUM);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic RST_DISABLE   = 1'b1;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam data_t ZERO_WORD     = '0;
    localparam addr_t ZERO_REG_ADDR = '0;

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        SRC_ZERO    = 2'd0,
        SRC_BYPASS  = 2'd1,
        SRC_STORAGE = 2'd2
    } read_src_e;

    // True when the write-back in flight targets the register being read.
    function automatic logic write_hit(input logic  write_en,
                                       input addr_t write_addr,
                                       input addr_t read_addr);
        return (write_en == WRITE_ENABLE) && (write_addr == read_addr);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bus between the pipeline (ID read requests, WB writes, debug probe) and
// the register file.
interface reg_file_if;
    import reg_file_pkg::*;

    logic  read_en_1;
    addr_t read_addr_1;
    data_t read_data_1;

    logic  read_en_2;
    addr_t read_addr_2;
    data_t read_data_2;

    logic  write_en;
    addr_t write_addr;
    data_t write_data;

    addr_t debug_addr;
    data_t debug_data;

    // Pipeline side: issues reads and writes, consumes read data.
    modport master (
        output read_en_1, read_addr_1,
        output read_en_2, read_addr_2,
        output write_en, write_addr, write_data,
        output debug_addr,
        input  read_data_1, read_data_2, debug_data
    );

    // Register file side.
    modport slave (
        input  read_en_1, read_addr_1,
        input  read_en_2, read_addr_2,
        input  write_en, write_addr, write_data,
        input  debug_addr,
        output read_data_1, read_data_2, debug_data
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port with same-cycle write-back bypass.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  logic  i_rst,
    input  logic  i_read_en,
    input  addr_t i_read_addr,
    input  logic  i_write_en,
    input  addr_t i_write_addr,
    input  data_t i_write_data,
    input  data_t i_stored_data,
    output data_t o_read_data
);

    read_src_e w_src;

    // Pick the data source; reset, disable and $0 all outrank the bypass.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        w_src = SRC_STORAGE;
        if (i_rst == RST_ENABLE) begin
            w_src = SRC_ZERO;
        end else if (i_read_en != READ_ENABLE) begin
            w_src = SRC_ZERO;
        end else if (i_read_addr == ZERO_REG_ADDR) begin
            w_src = SRC_ZERO;
        end else if (write_hit(i_write_en, i_write_addr, i_read_addr)) begin
            w_src = SRC_BYPASS;
        end
    end

    // Drive the port from the chosen source.
    always_comb begin
        o_read_data = ZERO_WORD;
        unique case (w_src)
            SRC_BYPASS:  o_read_data = i_write_data;
            SRC_STORAGE: o_read_data = i_stored_data;
            default:     o_read_data = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 32 x 32 bits, $0 hard-wired to zero,
// two bypassed read ports for ID, one write port for WB, one debug probe.
module reg_file
    import reg_file_pkg::*;
(
    input logic        clk,
    input logic        rst,
    reg_file_if.slave  bus
);

    data_t r_regs [REG_NUM];

    data_t w_stored_1;
    data_t w_stored_2;

    // Storage update: async clear of every entry, WB write on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            // NOTE: the whole array must clear asynchronously, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= ZERO_WORD;
            end
        end else if ((bus.write_en == WRITE_ENABLE) && (bus.write_addr != ZERO_REG_ADDR)) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_regs[bus.write_addr] <= bus.write_data;
        end
    end

    // The 5-bit index covers every entry, so these lookups never go out of range.
    assign w_stored_1 = r_regs[bus.read_addr_1];
    assign w_stored_2 = r_regs[bus.read_addr_2];

    reg_file_read_port u_read_port_1 (
        .i_rst         (rst),
        .i_read_en     (bus.read_en_1),
        .i_read_addr   (bus.read_addr_1),
        .i_write_en    (bus.write_en),
        .i_write_addr  (bus.write_addr),
        .i_write_data  (bus.write_data),
        .i_stored_data (w_stored_1),
        .o_read_data   (bus.read_data_1)
    );

    reg_file_read_port u_read_port_2 (
        .i_rst         (rst),
        .i_read_en     (bus.read_en_2),
        .i_read_addr   (bus.read_addr_2),
        .i_write_en    (bus.write_en),
        .i_write_addr  (bus.write_addr),
        .i_write_data  (bus.write_data),
        .i_stored_data (w_stored_2),
        .o_read_data   (bus.read_data_2)
    );

    // Debug probe shows committed storage only, never the in-flight write.
    always_comb begin
        bus.debug_data = ZERO_WORD;
        if ((rst != RST_ENABLE) && (bus.debug_addr != ZERO_REG_ADDR)) begin
            bus.debug_data = r_regs[bus.debug_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file: the driver pushes the expected
// outputs for each cycle into a queue, a monitor pops and compares them.
module tb_reg_file;
    import reg_file_pkg::*;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q [$];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read rule for one port, straight from the behavioural description.
    function automatic logic [31:0] ref_read(input logic rst_v, input logic en, input logic [4:0] a,
                                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (!rst_v || !en || a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return model[a];
    endfunction

    // One cycle of stimulus: bus inputs just after the rising edge, rst one step later.
    task automatic drive_cycle(input string tag, input logic rst_v,
                               input logic re1, input logic [4:0] ra1,
                               input logic re2, input logic [4:0] ra2,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] da);
        exp_t e;
        @(posedge clk);
        #1;
        bus.read_en_1   = re1;
        bus.read_addr_1 = ra1;
        bus.read_en_2   = re2;
        bus.read_addr_2 = ra2;
        bus.write_en    = we;
        bus.write_addr  = wa;
        bus.write_data  = wd;
        bus.debug_addr  = da;
        #1;
        rst = rst_v;
        if (!rst_v) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end
        e.rd1 = ref_read(rst_v, re1, ra1, we, wa, wd);
        e.rd2 = ref_read(rst_v, re2, ra2, we, wa, wd);
        e.dbg = (!rst_v || da == 5'd0) ? 32'h0 : model[da];
        e.tag = tag;
        exp_q.push_back(e);
        if (rst_v && we && wa != 5'd0) model[wa] = wd;
    endtask

    // Monitor: outputs are combinational, so one expectation is due every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".rd1"}, bus.read_data_1, e.rd1);
                check({e.tag, ".rd2"}, bus.read_data_2, e.rd2);
                check({e.tag, ".dbg"}, bus.debug_data, e.dbg);
            end
        end
    end

    initial begin
        logic [4:0]  ra1, ra2, wa, da;
        logic [31:0] wd;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst             = 1'b0;
        bus.read_en_1   = 1'b0;
        bus.read_addr_1 = '0;
        bus.read_en_2   = 1'b0;
        bus.read_addr_2 = '0;
        bus.write_en    = 1'b0;
        bus.write_addr  = '0;
        bus.write_data  = '0;
        bus.debug_addr  = '0;

        // Power-up reset with reads enabled.
        drive_cycle("por", 1'b0, 1'b1, 5'd3, 1'b1, 5'd17, 1'b1, 5'd4, 32'hFFFF0000, 5'd4);
        drive_cycle("por", 1'b0, 1'b1, 5'd8, 1'b1, 5'd8,  1'b0, 5'd0, 32'h0, 5'd8);

        // Write $5, then reset for three cycles clears it.
        drive_cycle("t1_rel",  1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5);
        drive_cycle("t1_wr",   1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5);
        drive_cycle("t1_pre",  1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5);
        repeat (3) drive_cycle("t1_rst", 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5);
        drive_cycle("t1_post", 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5);

        // Write latency and read enable.
        drive_cycle("t2_wr",  1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, 5'd7);
        drive_cycle("t2_rd",  1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7);
        drive_cycle("t2_dis", 1'b1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7);

        // $0 is never written and never bypassed.
        drive_cycle("t3_wr", 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0);
        drive_cycle("t3_rd", 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);

        // Bypass on both ports while debug still shows the old value.
        drive_cycle("t4_init", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h11111111, 5'd9);
        drive_cycle("t4_byp",  1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 32'h22222222, 5'd9);
        drive_cycle("t4_after", 1'b1, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 32'h0, 5'd9);

        // Fill every register, then sweep the ports in opposite orders.
        for (int i = 1; i < 32; i++) begin
            drive_cycle("t5_fill", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 32'hA0000000 + i, 5'(i));
        end
        for (int i = 1; i < 32; i++) begin
            drive_cycle("t5_sweep", 1'b1, 1'b1, 5'(i), 1'b1, 5'(32 - i), 1'b0, 5'd0, 32'h0, 5'(i));
        end

        // Random traffic; write address often aimed at a read address.
        for (int n = 0; n < 300; n++) begin
            ra1 = 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       wa = ra1;
                1:       wa = ra2;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            da = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
            wd = $urandom;
            drive_cycle("rand", 1'b1, 1'($urandom_range(0, 3) != 0), ra1,
                        1'($urandom_range(0, 3) != 0), ra2,
                        1'($urandom_range(0, 1)), wa, wd, da);
        end

        // Async reset mid-cycle while a write to $3 is pending.
        drive_cycle("t6_pre",  1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33333333, 5'd3);
        drive_cycle("t6_drop", 1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h44444444, 5'd3);
        drive_cycle("t6_hold", 1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h55555555, 5'd3);
        drive_cycle("t6_rel",  1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3);
        drive_cycle("t6_chk",  1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3);

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
General-purpose register file for the MIPS core, with 32 entries of 32 bits and register $0 hard-wired to zero.
- Responder to the ID stage read requests: two read ports, each with an enable and an address.
- Write target of the WB stage.
- Reads are combinational and return same-cycle write-back data through an internal bypass.
- Its outputs feed the RegReadProxy forwarding mux in ID.

Parameters:
REG_NUM, 32, number of architectural registers (addressed by `REG_ADDR_BUS, 5 bits)
DATA_WIDTH, 32, register width (`DATA_BUS)

Ports:
clk  input  1  core clock; all register state updates on its rising edge
rst  input  1  reset, asynchronous and active-low (`RST_ENABLE == 1'b0); clears all state
read_en_1  input  1  read port 1 enable (from ID)
read_addr_1  input  5  read port 1 register index
read_data_1  output  32  read port 1 data
read_en_2  input  1  read port 2 enable (from ID)
read_addr_2  input  5  read port 2 register index
read_data_2  output  32  read port 2 data
write_en  input  1  write enable (from WB)
write_addr  input  5  write register index
write_data  input  32  write data
debug_addr  input  5  debug/bench observation index
debug_data  output  32  contents of debug_addr, storage only, no bypass

Behaviour:
- Storage: 32 x 32-bit array; entry 0 never written and always reads 0.
- Reset, asynchronous (rst low):
  - all 32 entries clear to 0 immediately, without waiting for clk;
  - read_data_1, read_data_2 and debug_data are `ZERO_WORD while rst is low, regardless of enables and addresses.
- Write:
  - on posedge clk with rst high, write_en high and write_addr != 0: regs[write_addr] <= write_data;
  - write_addr == 0: no state change;
  - write_en low: no state change;
  - latency is 1 cycle: the value is visible in storage from the next cycle on.
- Read port n (n = 1, 2), combinational, priority in this order:
  1. rst low -> 0
  2. read_en_n low -> 0
  3. read_addr_n == 0 -> 0
  4. write_en high and write_addr == read_addr_n -> write_data (same-cycle bypass; this removes the WB->ID hazard)
  5. otherwise -> regs[read_addr_n]
- Both ports are independent:
  - they may read the same address in the same cycle, with identical results;
  - both may hit the bypass at once.
- debug_data = regs[debug_addr]:
  - no bypass; reads 0 for addr 0 and during reset.
- Reset released mid-cycle: the first write happens at the first posedge after rst goes high. A write coincident with the rst deassertion edge is not guaranteed; WB is idle out of reset.
- No X propagation:
  - outputs are fully defined for every input combination;
  - undefined addresses cannot occur because the 5-bit index covers all 32 entries.

Decomposition:
- Shared defines (global_def.v): `RST_ENABLE / `RST_DISABLE, `READ_ENABLE / `READ_DISABLE, `WRITE_ENABLE / `WRITE_DISABLE, `ZERO_WORD, `ZERO_REG_ADDR, `DATA_BUS, `REG_ADDR_BUS, and a new `REG_NUM (32).
- One sub-module is natural: reg_file_read_port, the combinational read-with-bypass priority logic, instantiated twice. Storage and the write logic stay in reg_file.

Test Plan:
1. Hold rst low for 3 cycles after prior writes of 0xDEADBEEF to $5 -> debug_data(5) = 0. Assert read_en_1 on $5 during reset -> read_data_1 = 0.
2. Write $7 = 0x12345678 in cycle N, then read port 1 at $7 in cycle N+1 -> 0x12345678. With read_en_1 = 0 at the same address -> 0.
3. Write $0 = 0xFFFFFFFF, then read $0 on both ports and debug -> all 0, including in the same cycle as the write (no bypass for $0).
4. Bypass: $9 holds 0x11111111; in one cycle write_en = 1, write_addr = 9, write_data = 0x22222222, both ports read $9 -> both return 0x22222222 while debug_data = 0x11111111. The next cycle debug_data = 0x22222222.
5. Fill $1..$31 with value 0xA0000000 + index, then sweep both ports in opposite orders -> each returns its value; no aliasing between entries.
6. Assert rst asynchronously mid-cycle while a write to $3 is pending -> outputs drop to 0 without a clk edge, and $3 remains 0 after release.
